// File: rtl/radio_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : radio_rx_deserializer
// Brief    : Oversampled UART-style serial receiver with a small byte FIFO.
//            Optional even-parity bit enabled by macro RADIO_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module radio_rx_deserializer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       Rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_error,
    output logic       overrun
);

    localparam int              c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0]      c_BIT_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0]      c_HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_AW:0]   c_FULL      = (c_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef RADIO_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    logic            r_rx_meta;
    logic            r_rx_sync;
    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_clk_cnt;
    logic [7:0]      w_clk_cnt_next;
    logic [2:0]      r_bit_cnt;
    logic [2:0]      w_bit_cnt_next;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic            w_push_req;
    logic            w_frame_err;
    logic            r_frame_error;
    logic            r_overrun;
`ifdef RADIO_RX_PARITY_EN
    logic            r_par_err;
    logic            w_par_err_next;
`endif

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= Rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt + 8'd1;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_push_req     = 1'b0;
        w_frame_err    = 1'b0;
`ifdef RADIO_RX_PARITY_EN
        w_par_err_next = r_par_err;
`endif
        case (r_state)
            S_IDLE: begin
                w_clk_cnt_next = 8'd0;
                if (!r_rx_sync) begin
                    w_state_next   = S_START;
                    w_bit_cnt_next = 3'd0;
`ifdef RADIO_RX_PARITY_EN
                    w_par_err_next = 1'b0;
`endif
                end
            end
            S_START: begin
                // Mid-bit check: a line that is high again was only a glitch
                if (r_clk_cnt == c_HALF_LAST) begin
                    w_clk_cnt_next = 8'd0;
                    w_state_next   = r_rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_cnt_next = 8'd0;
                    w_shift_next   = {r_rx_sync, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef RADIO_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef RADIO_RX_PARITY_EN
            S_PARITY: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_cnt_next = 8'd0;
                    w_par_err_next = ^{r_shift, r_rx_sync};
                    w_frame_err    = ^{r_shift, r_rx_sync};
                    w_state_next   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_cnt_next = 8'd0;
                    if (r_rx_sync) begin
`ifdef RADIO_RX_PARITY_EN
                        w_push_req = !r_par_err;
`else
                        w_push_req = 1'b1;
`endif
                        w_state_next = S_IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                w_clk_cnt_next = 8'd0;
                if (r_rx_sync) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_clk_cnt_next = 8'd0;
                w_state_next   = S_IDLE;
            end
        endcase
        // Disarming abandons any partial frame silently
        if (!enable) begin
            w_state_next   = S_IDLE;
            w_clk_cnt_next = 8'd0;
            w_push_req     = 1'b0;
            w_frame_err    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_clk_cnt     <= 8'd0;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'd0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
`ifdef RADIO_RX_PARITY_EN
            r_par_err     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_clk_cnt     <= w_clk_cnt_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_shift       <= w_shift_next;
            r_frame_error <= w_frame_err;
            r_overrun     <= w_overrun;
`ifdef RADIO_RX_PARITY_EN
            r_par_err     <= w_par_err_next;
`endif
        end
    end

    assign rx_valid  = (r_count != '0);
    assign w_full    = (r_count == c_FULL);
    assign w_pop     = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_overrun = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rx_data     = rx_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign busy        = (r_state != S_IDLE);
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_radio_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_radio_rx_deserializer
// Brief    : Directed vector bench for radio_rx_deserializer (4 clk/bit, 4-deep).
// Revision : 1.0 - initial release
// ============================================================================
module tb_radio_rx_deserializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       Rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       frame_error;
    logic       overrun;

    radio_rx_deserializer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .Rx          (Rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .busy        (busy),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par;
        logic       exp_push;
        int         exp_err;
    } vec_t;

    vec_t       vecs [8];
    int         n_vec;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_err    = 0;
    int         n_ovr    = 0;
    logic [7:0] got [$];
    int         e0;
    int         o0;
    int         q0;

    always @(negedge clk) begin
        if (frame_error === 1'b1) n_err++;
        if (overrun === 1'b1) n_ovr++;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) got.push_back(rx_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        Rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        Rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RADIO_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) Rx = 1'b0;
`endif
        send_bit(stop);
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic s, input logic p,
                                input logic push, input int err);
        vec_t v;
        v.data = d; v.stop = s; v.par = p; v.exp_push = push; v.exp_err = err;
        return v;
    endfunction

    task automatic mark();
        e0 = n_err;
        o0 = n_ovr;
        q0 = got.size();
    endtask

    task automatic check_byte(input string name, input logic [7:0] d);
        check({name, "_push"}, got.size() - q0, 1);
        if (got.size() > q0) check({name, "_data"}, got[got.size() - 1], d);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        vecs[n_vec++] = mk(8'h55, 1'b1, ^8'h55, 1'b1, 0);
        vecs[n_vec++] = mk(8'hA5, 1'b0, ^8'hA5, 1'b0, 1);
        vecs[n_vec++] = mk(8'h00, 1'b1, ^8'h00, 1'b1, 0);
        vecs[n_vec++] = mk(8'hFF, 1'b1, ^8'hFF, 1'b1, 0);
        vecs[n_vec++] = mk(8'h3C, 1'b1, ^8'h3C, 1'b1, 0);
        vecs[n_vec++] = mk(8'h81, 1'b1, ^8'h81, 1'b1, 0);
`ifdef RADIO_RX_PARITY_EN
        vecs[n_vec++] = mk(8'h03, 1'b1, 1'b0, 1'b1, 0);
        vecs[n_vec++] = mk(8'h03, 1'b1, 1'b1, 1'b0, 1);
`endif

        rst = 1'b1; enable = 1'b1; Rx = 1'b1; rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        idle(4);

        for (int i = 0; i < n_vec; i++) begin
            mark();
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].par);
            if (!vecs[i].stop) begin
                repeat (6) @(posedge clk);
                #1;
                check($sformatf("v%0d_busy_hold", i), busy, 1);
            end
            idle(8);
            check($sformatf("v%0d_busy_idle", i), busy, 0);
            check($sformatf("v%0d_err", i), n_err - e0, vecs[i].exp_err);
            check($sformatf("v%0d_ovr", i), n_ovr - o0, 0);
            if (vecs[i].exp_push) check_byte($sformatf("v%0d", i), vecs[i].data);
            else check($sformatf("v%0d_nopush", i), got.size() - q0, 0);
        end

        // one-cycle glitch on the line
        mark();
        Rx = 1'b0;
        @(posedge clk);
        #1;
        Rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("glitch_busy", busy, 0);
        idle(8);
        check("glitch_err", n_err - e0, 0);
        check("glitch_nopush", got.size() - q0, 0);

        // overrun with consumer stalled
        rx_ready = 1'b0;
        mark();
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, ^(8'(k)));
            idle(4);
        end
        idle(4);
        check("ovr_pulse", n_ovr - o0, 1);
        check("ovr_err", n_err - e0, 0);
        check("ovr_valid", rx_valid, 1);
        check("ovr_head", rx_data, 8'h01);
        rx_ready = 1'b1;
        idle(8);
        check("drain_cnt", got.size() - q0, 4);
        for (int j = 0; j < 4; j++) begin
            if (got.size() > q0 + j) check($sformatf("drain_%0d", j), got[q0 + j], 8'(j + 1));
        end
        check("drain_valid", rx_valid, 0);

        // reset during bit 3 of 0xFF
        mark();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        Rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rstmid_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_valid", rx_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(30);
        check("rstmid_nopush", got.size() - q0, 0);
        check("rstmid_idle", busy, 0);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        idle(8);
        check_byte("rstmid_next", 8'h3C);

        // enable dropped during bit 3 of 0xFF
        mark();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        Rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("en_pre_busy", busy, 1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("en_busy", busy, 0);
        idle(30);
        enable = 1'b1;
        idle(8);
        check("en_nopush", got.size() - q0, 0);
        check("en_err", n_err - e0, 0);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        idle(8);
        check_byte("en_next", 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/radio_rx_deserializer.md
RADIO_RX_DESERIALIZER -- requirements
Module: radio_rx_deserializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8: clk cycles per serial bit; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4: received-byte buffer entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  high = receiver armed; low = framer held idle.
REQ-006 Rx  input  1  serial line; idle high; asynchronous to clk.
REQ-007 rx_data  output  8  byte at FIFO head; valid only while rx_valid=1.
REQ-008 rx_valid  output  1  FIFO non-empty.
REQ-009 rx_ready  input  1  consumer accepts head byte when rx_valid&&rx_ready.
REQ-010 busy  output  1  framer not in IDLE.
REQ-011 frame_error  output  1  one-cycle pulse: bad stop (or parity) bit.
REQ-012 overrun  output  1  one-cycle pulse: completed byte dropped, FIFO full.

Function
REQ-013 Rx SHALL pass a 2-flop synchronizer (reset value 1); all framer decisions use the synchronized value.
REQ-014 States SHALL be IDLE, START, DATA, PARITY (only with macro), STOP, WAIT_IDLE.
REQ-015 IDLE->START on synchronized Rx=0 while enable=1; bit counter cleared.
REQ-016 START: after CLKS_PER_BIT/2 (floor) cycles sample; 0 -> DATA, 1 -> IDLE (glitch rejected, no error, nothing stored).
REQ-017 DATA: sample every CLKS_PER_BIT cycles, 8 samples, shifted in LSB first; after 8th -> PARITY or STOP.
REQ-018 STOP: sample after CLKS_PER_BIT cycles; 1 -> push byte, IDLE; 0 -> frame_error pulse, byte discarded, WAIT_IDLE.
REQ-019 WAIT_IDLE -> IDLE on first synchronized Rx=1.
REQ-020 Push occurs in the cycle the stop bit is sampled; rx_valid rises the following cycle.
REQ-021 Pop on rx_valid&&rx_ready; rx_data shows next entry the following cycle.
REQ-022 Push when full and no pop: byte dropped, overrun pulse, FIFO unchanged.
REQ-023 Push and pop same cycle when full: both performed, no overrun; when empty: push only takes effect after the cycle (no bypass).
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-025 enable=0 SHALL force framer to IDLE next cycle, discarding partial byte without error; FIFO contents and pop remain functional.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE, counters 0, shift register 0, FIFO empty, rx_valid 0, rx_data 0, busy 0, frame_error 0, overrun 0, synchronizer 1.
REQ-028 rst asserted mid-frame SHALL abandon the frame; after release the receiver waits for a new start edge.

Configuration
REQ-029 Macro RADIO_RX_PARITY_EN: when defined, PARITY state samples one bit after data; even parity over 8 data bits plus parity bit required; mismatch -> frame_error, byte discarded, then STOP sampled normally (no push).
REQ-030 Without RADIO_RX_PARITY_EN: no PARITY state; frame is start, 8 data, stop.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Idle-high line, send 0x55 frame, rx_ready=1 -> rx_valid one cycle, rx_data=0x55, no errors.
REQ-032 Send 0xA5 with stop bit 0 -> frame_error pulse once, rx_valid stays 0, busy held until Rx returns high.
REQ-033 Rx low 1 cycle then high -> no byte, no error, busy returns 0 within 3 cycles.
REQ-034 rx_ready=0, send 0x01..0x05 -> four bytes 0x01..0x04 held, overrun pulse on 5th; draining yields 0x01..0x04 in order.
REQ-035 Assert rst (and separately drop enable) during bit 3 of 0xFF -> busy 0, no push; next frame 0x3C received correctly.
REQ-036 With RADIO_RX_PARITY_EN: 0x03 with parity 0 accepted; 0x03 with parity 1 -> frame_error, no push.
